// File: rtl/if_stream_loader.sv
// Streams a row-major feature-map tile from a sync-read memory into the IF FIFO,
// tagging each element with SOR/EOR and packing PAR_WRITE elements per write.
module if_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   start,
    input  logic [ADDR_WIDTH-1:0]                  base_addr,
    input  logic [LEN_WIDTH-1:0]                   row_len,
    input  logic [LEN_WIDTH-1:0]                   row_cnt,
    output logic                                   mem_ren,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata,
    input  logic                                   if_full,
    output logic                                   if_wen,
    output logic [PAR_WRITE*(DATA_WIDTH+2)-1:0]    if_din,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);
    localparam int EW = DATA_WIDTH + 2;
    localparam int CW = $clog2(PAR_WRITE + 1);
    localparam int TW = 2 * LEN_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

    state_e                       state_q, state_d;
    logic [LEN_WIDTH-1:0]         len_q, len_d;
    logic [LEN_WIDTH-1:0]         col_q, col_d;
    logic [TW-1:0]                rem_q, rem_d;
    logic                         mem_ren_q, mem_ren_d;
    logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
    logic [1:0]                   ren_tag_q, ren_tag_d;
    logic                         rd_vld_q, rd_vld_d;
    logic [1:0]                   rd_tag_q, rd_tag_d;
    logic [PAR_WRITE-1:0][EW-1:0] coll_q, coll_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         out_vld_q, out_vld_d;
    logic [PAR_WRITE-1:0][EW-1:0] out_q, out_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic [TW-1:0]                total;
    logic [PAR_WRITE-1:0][EW-1:0] word;
    logic [CW:0]                  cnt_new, reserved;
    logic                         move, can_issue;

    assign total = TW'(row_len) * TW'(row_cnt);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        col_d      = col_q;
        rem_d      = rem_q;
        mem_ren_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        ren_tag_d  = ren_tag_q;
        rd_vld_d   = mem_ren_q;
        rd_tag_d   = ren_tag_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q & if_full;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        // Returning element completes the word in place, so a full word can hand off the same cycle.
        word    = coll_q;
        cnt_new = {1'b0, cnt_q};
        for (int k = 0; k < PAR_WRITE; k++) begin
            if (rd_vld_q && CW'(k) == cnt_q) word[k] = {rd_tag_q, mem_rdata};
        end
        if (rd_vld_q) cnt_new = cnt_new + 1'b1;

        move = (cnt_new == (CW+1)'(PAR_WRITE)) && (!out_vld_q || !if_full);
        if (move) begin
            out_d     = word;
            out_vld_d = 1'b1;
            coll_d    = '0;
            cnt_d     = '0;
        end else begin
            coll_d = word;
            cnt_d  = cnt_new[CW-1:0];
        end

        // A new read lands two cycles out; only fill the last slot if that word is sure to leave.
        reserved  = {1'b0, cnt_d} + (CW+1)'(mem_ren_q);
        can_issue = (reserved < (CW+1)'(PAR_WRITE)) ||
                    ((reserved == (CW+1)'(PAR_WRITE)) && !out_vld_d);

        case (state_q)
            IDLE: if (start) begin
                len_d = row_len;
                err_d = 1'b0;
                if (total == '0) begin
                    state_d = DONE;
                end else if ((total % TW'(PAR_WRITE)) != '0) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d    = FETCH;
                    busy_d     = 1'b1;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = base_addr;
                    ren_tag_d  = {1'b1, row_len == LEN_WIDTH'(1)};
                    col_d      = (row_len == LEN_WIDTH'(1)) ? '0 : LEN_WIDTH'(1);
                    rem_d      = total - 1'b1;
                end
            end
            FETCH: begin
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end else if (can_issue) begin
                    mem_ren_d  = 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                    ren_tag_d  = {col_q == '0, col_q == len_q - 1'b1};
                    col_d      = (col_q == len_q - 1'b1) ? '0 : col_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                end
            end
            DRAIN: if (cnt_q == '0 && !out_vld_q && !mem_ren_q && !rd_vld_q) begin
                state_d = DONE;
                busy_d  = 1'b0;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            col_q      <= '0;
            rem_q      <= '0;
            mem_ren_q  <= 1'b0;
            mem_addr_q <= '0;
            ren_tag_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_tag_q   <= '0;
            coll_q     <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            col_q      <= col_d;
            rem_q      <= rem_d;
            mem_ren_q  <= mem_ren_d;
            mem_addr_q <= mem_addr_d;
            ren_tag_q  <= ren_tag_d;
            rd_vld_q   <= rd_vld_d;
            rd_tag_q   <= rd_tag_d;
            coll_q     <= coll_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_ren  = mem_ren_q;
    assign mem_addr = mem_addr_q;
    assign if_wen   = out_vld_q & ~if_full;
    assign if_din   = out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_if_stream_loader.sv
// Randomized scoreboard bench: a queue model predicts read addresses and packed
// FIFO words per transfer; a negedge monitor pops and compares DUT activity.
module tb_if_stream_loader;
    localparam int DW = 8, PW = 2, AW = 12, LW = 8;
    localparam int EW = DW + 2;
    localparam int WW = PW * EW;

    logic          clk = 1'b0, rstn = 1'b0, start = 1'b0, if_full = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] row_len = '0, row_cnt = '0;
    logic          mem_ren, if_wen, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [WW-1:0] if_din;

    logic [DW-1:0] mem [1<<AW];
    logic [AW-1:0] addr_q[$];
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] wlog[$];
    logic [WW-1:0] prev_din = '0;
    int checks = 0, failures = 0;
    int gcyc = 0, st_cyc = 0, fmode = 0;

    if_stream_loader #(.DATA_WIDTH(DW), .PAR_WRITE(PW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .row_len(row_len),
        .row_cnt(row_cnt), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .if_full(if_full), .if_wen(if_wen), .if_din(if_din), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) gcyc <= gcyc + 1;
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: element i of the tile sits at base+i; its column is i mod row_len.
    task automatic model(input logic [AW-1:0] base, input int len, input int cnt);
        logic [WW-1:0] w;
        int slot;
        w = '0;
        slot = 0;
        for (int i = 0; i < len * cnt; i++) begin
            int col;
            logic [AW-1:0] a;
            col = i % len;
            a = base + AW'(i);
            addr_q.push_back(a);
            w[slot*EW +: EW] = {col == 0, col == len - 1, mem[a]};
            slot++;
            if (slot == PW) begin
                exp_q.push_back(w);
                w = '0;
                slot = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        case (fmode)
            1:       if_full = ($urandom_range(0, 2) == 0);
            2:       if_full = ((gcyc - st_cyc) >= 3) && ((gcyc - st_cyc) <= 12);
            default: if_full = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        int rel;
        rel = gcyc - st_cyc;
        if (rstn) begin
            if (mem_ren) begin
                if (addr_q.size() == 0) chk("extra_read", mem_ren, 0);
                else chk("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (if_wen) begin
                wlog.push_back(if_din);
                if (exp_q.size() == 0) chk("extra_write", if_wen, 0);
                else chk("if_din", if_din, exp_q.pop_front());
            end
            if (fmode == 2 && rel >= 3 && rel <= 12) chk("bp_no_wen", if_wen, 0);
            if (fmode == 2 && rel >= 5 && rel <= 12) chk("bp_din_hold", if_din, prev_din);
            if (fmode == 2 && rel >= 7 && rel <= 12) chk("bp_ren_stop", mem_ren, 0);
        end
        prev_din <= if_din;
    end

    task automatic run(input logic [AW-1:0] base, input int len, input int cnt,
                       input int fm, input bit bstart);
        int total, k;
        bit valid, eerr, seen, bz;
        total = len * cnt;
        eerr  = (total != 0) && (total % PW != 0);
        valid = (total != 0) && !eerr;
        if (valid) model(base, len, cnt);
        wlog.delete();
        fmode = fm;
        @(posedge clk); #1;
        base_addr = base; row_len = LW'(len); row_cnt = LW'(cnt); start = 1'b1; st_cyc = gcyc;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom); row_len = LW'($urandom); row_cnt = LW'($urandom);
        k = 1; seen = 0;
        while (!seen && k < 600) begin
            #3;
            if (k == 1) chk("busy_rise", busy, valid);
            bz = busy;
            if (done) seen = 1;
            else begin
                @(posedge clk); #1;
                start = bstart && bz && (k == 3 || k == 7);
                k++;
            end
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", done, 1);
        else begin
            if (!valid) chk("degen_done_latency", k, 2);
            chk("err", err, eerr);
            chk("busy_at_done", busy, 0);
            chk("words_left", exp_q.size(), 0);
            chk("reads_left", addr_q.size(), 0);
            chk("write_count", wlog.size(), valid ? total / PW : 0);
            @(posedge clk); #3;
            chk("done_one_cycle", done, 0);
        end
        repeat (3) @(posedge clk);
        fmode = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 8; i++) mem[16 + i] = DW'(i + 1);
        #3 chk("reset_outputs", {mem_ren, mem_addr, if_wen, if_din, busy, done, err}, '0);
        #20 rstn = 1'b1;

        run(12'h010, 4, 2, 0, 0);
        if (wlog.size() >= 3) begin
            chk("basic_w0", wlog[0], 20'hA01);
            chk("basic_w1_slot1", wlog[1][19:10], 10'h104);
            chk("basic_w2_slot0", wlog[2][9:0], 10'h205);
        end
        run(12'h010, 4, 2, 2, 0);
        run(12'h040, 0, 5, 0, 0);
        run(12'h040, 3, 1, 0, 0);
        run(12'h200, 1, 4, 0, 0);
        for (int i = 0; i < wlog.size(); i++)
            chk("len1_tags", {wlog[i][19:18], wlog[i][9:8]}, 4'hF);
        run(12'hFFE, 4, 1, 0, 0);
        for (int i = 0; i < 12; i++)
            run(AW'($urandom), $urandom_range(1, 8), $urandom_range(1, 6), 1, 1);

        model(12'h100, 4, 3);
        @(posedge clk); #1;
        base_addr = 12'h100; row_len = 8'd4; row_cnt = 8'd3; start = 1'b1; st_cyc = gcyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk("midreset_outputs", {mem_ren, mem_addr, if_wen, if_din, busy, done, err}, '0);
        addr_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        run(12'h300, 4, 2, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
